// File: rtl/zion_riscv_isa_lib_add_sub_de.sv
// AddSub decode-side producer: decodes RV32I/RV64I add/sub/compare/address
// instructions into an {op, s1, s2} bundle for the AddSub executor, and
// buffers results in a two-entry elastic buffer (output reg + skid reg).
module zion_riscv_isa_lib_add_sub_de #(
  parameter int RV64 = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [31:0]             iInstr,
  input  logic [32*(RV64+1)-1:0]  iRs1Dat,
  input  logic [32*(RV64+1)-1:0]  iRs2Dat,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [RV64+1:0]         oOp,
  output logic [32*(RV64+1)-1:0]  oS1,
  output logic [32*(RV64+1)-1:0]  oS2,
  output logic                    oUnsignedFlg,
  output logic [1:0]              oCls,
  output logic                    oHit
);

  localparam int  XLen   = 32 * (RV64 + 1);
  localparam int  OpW    = RV64 + 2;
  localparam int  WBit   = OpW - 1;
  localparam bit  IsRv64 = (RV64 != 0);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp32   = 7'b0111011;
  localparam logic [6:0] OpcOpImm32= 7'b0011011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;

  localparam logic [1:0] ClsArith = 2'd0;
  localparam logic [1:0] ClsSlt   = 2'd1;
  localparam logic [1:0] ClsBr    = 2'd2;
  localparam logic [1:0] ClsMem   = 2'd3;

  typedef struct packed {
    logic [OpW-1:0]  op;
    logic [XLen-1:0] s1;
    logic [XLen-1:0] s2;
    logic            uns;
    logic [1:0]      cls;
    logic            hit;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  // ---------------- decode ----------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLen-1:0] immI;
  logic [XLen-1:0] immS;

  assign opcode = iInstr[6:0];
  assign funct3 = iInstr[14:12];
  assign funct7 = iInstr[31:25];
  assign immI   = {{(XLen-12){iInstr[31]}}, iInstr[31:20]};
  assign immS   = {{(XLen-12){iInstr[31]}}, iInstr[31:25], iInstr[11:7]};

  logic [OpW-1:0]  decOp;
  logic            decUns;
  logic [1:0]      decCls;
  logic [XLen-1:0] decS2;
  logic            decHit;
  bundle_t         decBundle;

  // Classify the instruction; op bits select add vs. sub, WBit marks .W forms
  always_comb begin
    decOp  = '0;
    decUns = 1'b0;
    decCls = ClsArith;
    decS2  = iRs2Dat;
    case (opcode)
      OpcOp: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          decOp[0] = 1'b1;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          decOp[1] = 1'b1;
        end else if (funct7 == 7'b0000000 && funct3[2:1] == 2'b01) begin
          decOp[1] = 1'b1;
          decCls   = ClsSlt;
          decUns   = funct3[0];
        end
      end
      OpcOpImm: begin
        decS2 = immI;
        if (funct3 == 3'b000) begin
          decOp[0] = 1'b1;
        end else if (funct3[2:1] == 2'b01) begin
          decOp[1] = 1'b1;
          decCls   = ClsSlt;
          decUns   = funct3[0];
        end
      end
      OpcOp32: begin
        if (IsRv64 && funct3 == 3'b000 && funct7 == 7'b0000000) begin
          decOp[0]    = 1'b1;
          decOp[WBit] = 1'b1;
        end else if (IsRv64 && funct3 == 3'b000 && funct7 == 7'b0100000) begin
          decOp[1]    = 1'b1;
          decOp[WBit] = 1'b1;
        end
      end
      OpcOpImm32: begin
        decS2 = immI;
        if (IsRv64 && funct3 == 3'b000) begin
          decOp[0]    = 1'b1;
          decOp[WBit] = 1'b1;
        end
      end
      OpcBranch: begin
        // BEQ/BNE (and reserved 010/011) use the equality path, not AddSub
        if (funct3[2]) begin
          decOp[1] = 1'b1;
          decCls   = ClsBr;
          decUns   = funct3[1];
        end
      end
      OpcLoad: begin
        decS2    = immI;
        decOp[0] = 1'b1;
        decCls   = ClsMem;
      end
      OpcStore: begin
        decS2    = immS;
        decOp[0] = 1'b1;
        decCls   = ClsMem;
      end
      default: ;
    endcase
    decHit = decOp[0] | decOp[1];
  end

  // Non-AddSub instructions still flow through, but as an all-zero bundle
  always_comb begin
    decBundle     = '0;
    decBundle.hit = decHit;
    if (decHit) begin
      decBundle.op  = decOp;
      decBundle.s1  = iRs1Dat;
      decBundle.s2  = decS2;
      decBundle.uns = decUns;
      decBundle.cls = decCls;
    end
  end

  // ---------------- elastic buffer ----------------
  state_t  stateReg, stateNext;
  bundle_t orReg, skReg;
  logic    accept, drain, loadOr, loadSk, skToOr;

  assign oValid = (stateReg != EMPTY);
  assign oReady = (stateReg != TWO);
  assign accept = iValid & oReady;
  assign drain  = oValid & iReady;

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateReg <= EMPTY;
    else     stateReg <= stateNext;
  end

  // Next occupancy and which register captures the incoming bundle
  always_comb begin
    stateNext = stateReg;
    loadOr    = 1'b0;
    loadSk    = 1'b0;
    skToOr    = 1'b0;
    case (stateReg)
      EMPTY: begin
        if (accept) begin
          loadOr    = 1'b1;
          stateNext = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          loadOr = 1'b1;
        end else if (accept) begin
          loadSk    = 1'b1;
          stateNext = TWO;
        end else if (drain) begin
          stateNext = EMPTY;
        end
      end
      TWO: begin
        // oReady is low here, so no new bundle competes with the skid move
        if (drain) begin
          skToOr    = 1'b1;
          stateNext = ONE;
        end
      end
      default: stateNext = EMPTY;
    endcase
  end

  // Output register: new bundle or promoted skid entry; held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         orReg <= '0;
    else if (loadOr) orReg <= decBundle;
    else if (skToOr) orReg <= skReg;
  end

  // Skid register captures a bundle that arrives while the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         skReg <= '0;
    else if (loadSk) skReg <= decBundle;
  end

  assign oOp          = orReg.op;
  assign oS1          = orReg.s1;
  assign oS2          = orReg.s2;
  assign oUnsignedFlg = orReg.uns;
  assign oCls         = orReg.cls;
  assign oHit         = orReg.hit;

  // A hit bundle must request exactly one of add or subtract
  assert property (@(posedge clk) disable iff (rst)
    (oValid && oHit) |-> (oOp[1:0] == 2'b01 || oOp[1:0] == 2'b10));

endmodule

// File: tb/tb_zion_riscv_isa_lib_add_sub_de.sv
// Directed bench for the AddSub decode producer: table of decode vectors
// run on an RV64 and an RV32 instance, plus backpressure and reset sequences.
module tb_zion_riscv_isa_lib_add_sub_de;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iValid = 1'b0;
  logic        iReady = 1'b1;
  logic [31:0] iInstr = '0;
  logic [63:0] rs1_64 = '0, rs2_64 = '0;
  logic [31:0] rs1_32 = '0, rs2_32 = '0;

  logic        oReady64, oValid64, oUns64, oHit64;
  logic [2:0]  oOp64;
  logic [63:0] oS1_64, oS2_64;
  logic [1:0]  oCls64;

  logic        oReady32, oValid32, oUns32, oHit32;
  logic [1:0]  oOp32;
  logic [31:0] oS1_32, oS2_32;
  logic [1:0]  oCls32;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  zion_riscv_isa_lib_add_sub_de #(.RV64(1)) dut64 (
    .clk(clk), .rst(rst), .iValid(iValid), .oReady(oReady64), .iInstr(iInstr),
    .iRs1Dat(rs1_64), .iRs2Dat(rs2_64), .oValid(oValid64), .iReady(iReady),
    .oOp(oOp64), .oS1(oS1_64), .oS2(oS2_64), .oUnsignedFlg(oUns64),
    .oCls(oCls64), .oHit(oHit64));

  zion_riscv_isa_lib_add_sub_de #(.RV64(0)) dut32 (
    .clk(clk), .rst(rst), .iValid(iValid), .oReady(oReady32), .iInstr(iInstr),
    .iRs1Dat(rs1_32), .iRs2Dat(rs2_32), .oValid(oValid32), .iReady(iReady),
    .oOp(oOp32), .oS1(oS1_32), .oS2(oS2_32), .oUnsignedFlg(oUns32),
    .oCls(oCls32), .oHit(oHit32));

  typedef struct {
    bit          rv64;
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [2:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic        uns;
    logic [1:0]  cls;
    logic        hit;
  } vec_t;

  localparam int NVec = 16;
  vec_t vecs [NVec];

  function automatic vec_t mk(bit rv64, logic [31:0] instr, logic [63:0] rs1,
                              logic [63:0] rs2, logic [2:0] op, logic [63:0] s1,
                              logic [63:0] s2, logic uns, logic [1:0] cls, logic hit);
    vec_t v;
    v.rv64 = rv64; v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.op = op;
    v.s1 = s1; v.s2 = s2; v.uns = uns; v.cls = cls; v.hit = hit;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // rv64 instr          rs1                    rs2                    op      s1                     s2                     u  cls hit
    vecs[0]  = mk(1, 32'h002081B3, 64'd5,                64'd7,                3'b001, 64'd5,                64'd7,                0, 0, 1); // ADD
    vecs[1]  = mk(1, 32'h402081B3, 64'd10,               64'd3,                3'b010, 64'd10,               64'd3,                0, 0, 1); // SUB
    vecs[2]  = mk(1, 32'hFFF00093, 64'd10,               64'h55,               3'b001, 64'd10,               64'hFFFFFFFF_FFFFFFFF, 0, 0, 1); // ADDI -1
    vecs[3]  = mk(0, 32'h0020E463, 64'd1,                64'hFFFFFFFF,         3'b010, 64'd1,                64'hFFFFFFFF,         1, 2, 1); // BLTU
    vecs[4]  = mk(0, 32'h00208463, 64'd1,                64'd2,                3'b000, 64'd0,                64'd0,                0, 0, 0); // BEQ
    vecs[5]  = mk(1, 32'h002081BB, 64'h1_00000001,       64'd2,                3'b101, 64'h1_00000001,       64'd2,                0, 0, 1); // ADDW
    vecs[6]  = mk(0, 32'h002081BB, 64'd1,                64'd2,                3'b000, 64'd0,                64'd0,                0, 0, 0); // ADDW on RV32
    vecs[7]  = mk(1, 32'hFFB13093, 64'h20,               64'd0,                3'b010, 64'h20,               64'hFFFFFFFF_FFFFFFFB, 1, 1, 1); // SLTIU -5
    vecs[8]  = mk(1, 32'h0020A1B3, 64'hFFFFFFFF_FFFFFFFF, 64'd1,               3'b010, 64'hFFFFFFFF_FFFFFFFF, 64'd1,               0, 1, 1); // SLT
    vecs[9]  = mk(1, 32'h0080A183, 64'h1000,             64'h77,               3'b001, 64'h1000,             64'd8,                0, 3, 1); // LW 8
    vecs[10] = mk(1, 32'hFE20AE23, 64'h2000,             64'h99,               3'b001, 64'h2000,             64'hFFFFFFFF_FFFFFFFC, 0, 3, 1); // SW -4
    vecs[11] = mk(0, 32'h0020D463, 64'd3,                64'd4,                3'b010, 64'd3,                64'd4,                0, 2, 1); // BGE
    vecs[12] = mk(1, 32'h000010B7, 64'd5,                64'd6,                3'b000, 64'd0,                64'd0,                0, 0, 0); // LUI
    vecs[13] = mk(1, 32'h402081BB, 64'd9,                64'd4,                3'b110, 64'd9,                64'd4,                0, 0, 1); // SUBW
    vecs[14] = mk(0, 32'hFFF00093, 64'd7,                64'd0,                3'b001, 64'd7,                64'hFFFFFFFF,         0, 0, 1); // ADDI -1 RV32
    vecs[15] = mk(1, 32'h0020B1B3, 64'd2,                64'd3,                3'b010, 64'd2,                64'd3,                1, 1, 1); // SLTU

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_oValid", 0, {63'd0, oValid64}, 64'd0);
    chk("rst_oReady", 0, {63'd0, oReady64}, 64'd1);
    chk("rst_oOp",    0, {61'd0, oOp64},    64'd0);
    chk("rst_oS1",    0, oS1_64,            64'd0);
    chk("rst_oS2",    0, oS2_64,            64'd0);
    chk("rst_oHit",   0, {63'd0, oHit64},   64'd0);
    chk("rst_oValid32", 0, {63'd0, oValid32}, 64'd0);

    // Decode table, one bundle per cycle with iReady held high
    iReady = 1'b1;
    for (int i = 0; i < NVec; i++) begin
      iInstr = vecs[i].instr;
      rs1_64 = vecs[i].rs1;
      rs2_64 = vecs[i].rs2;
      rs1_32 = vecs[i].rs1[31:0];
      rs2_32 = vecs[i].rs2[31:0];
      iValid = 1'b1;
      @(negedge clk);
      if (vecs[i].rv64) begin
        $display("[TB] vec%0d rv64 instr=%h op=%b s1=%h s2=%h cls=%0d u=%0d hit=%0d",
                 i, vecs[i].instr, oOp64, oS1_64, oS2_64, oCls64, oUns64, oHit64);
        chk("v_valid", i, {63'd0, oValid64}, 64'd1);
        chk("v_op",    i, {61'd0, oOp64},    {61'd0, vecs[i].op});
        chk("v_s1",    i, oS1_64,            vecs[i].s1);
        chk("v_s2",    i, oS2_64,            vecs[i].s2);
        chk("v_uns",   i, {63'd0, oUns64},   {63'd0, vecs[i].uns});
        chk("v_cls",   i, {62'd0, oCls64},   {62'd0, vecs[i].cls});
        chk("v_hit",   i, {63'd0, oHit64},   {63'd0, vecs[i].hit});
      end else begin
        $display("[TB] vec%0d rv32 instr=%h op=%b s1=%h s2=%h cls=%0d u=%0d hit=%0d",
                 i, vecs[i].instr, oOp32, oS1_32, oS2_32, oCls32, oUns32, oHit32);
        chk("v_valid", i, {63'd0, oValid32}, 64'd1);
        chk("v_op",    i, {62'd0, oOp32},    {61'd0, vecs[i].op});
        chk("v_s1",    i, {32'd0, oS1_32},   vecs[i].s1);
        chk("v_s2",    i, {32'd0, oS2_32},   vecs[i].s2);
        chk("v_uns",   i, {63'd0, oUns32},   {63'd0, vecs[i].uns});
        chk("v_cls",   i, {62'd0, oCls32},   {62'd0, vecs[i].cls});
        chk("v_hit",   i, {63'd0, oHit32},   {63'd0, vecs[i].hit});
      end
    end
    iValid = 1'b0;
    @(negedge clk);
    chk("drain_empty", 0, {63'd0, oValid64}, 64'd0);

    // Backpressure: three ADDs with iReady low, then release
    iInstr = 32'h002081B3;
    rs2_64 = 64'd0;
    iReady = 1'b0;
    rs1_64 = 64'd1; iValid = 1'b1;
    @(negedge clk);
    chk("bp_ready1", 1, {63'd0, oReady64}, 64'd1);
    rs1_64 = 64'd2;
    @(negedge clk);
    chk("bp_ready2", 2, {63'd0, oReady64}, 64'd0);
    rs1_64 = 64'd3;
    @(negedge clk);
    $display("[TB] bp stall valid=%0d ready=%0d s1=%h", oValid64, oReady64, oS1_64);
    chk("bp_hold_ready", 3, {63'd0, oReady64}, 64'd0);
    chk("bp_hold_valid", 3, {63'd0, oValid64}, 64'd1);
    chk("bp_hold_s1",    3, oS1_64,            64'd1);
    iReady = 1'b1;
    @(negedge clk);
    $display("[TB] bp out s1=%h ready=%0d", oS1_64, oReady64);
    chk("bp_out2",    4, oS1_64,            64'd2);
    chk("bp_ready_back", 4, {63'd0, oReady64}, 64'd1);
    @(negedge clk);
    iValid = 1'b0;
    $display("[TB] bp out s1=%h valid=%0d", oS1_64, oValid64);
    chk("bp_out3",    5, oS1_64,            64'd3);
    chk("bp_valid3",  5, {63'd0, oValid64}, 64'd1);
    @(negedge clk);
    chk("bp_empty",   6, {63'd0, oValid64}, 64'd0);
    chk("bp_ready_end", 6, {63'd0, oReady64}, 64'd1);

    // Asynchronous reset while both entries are full
    iReady = 1'b0;
    rs1_64 = 64'h11; iValid = 1'b1;
    @(negedge clk);
    rs1_64 = 64'h22;
    @(negedge clk);
    iValid = 1'b0;
    chk("r_full", 0, {63'd0, oReady64}, 64'd0);
    #2 rst = 1'b1;
    #1;
    $display("[TB] async rst valid=%0d ready=%0d s1=%h", oValid64, oReady64, oS1_64);
    chk("r_valid", 0, {63'd0, oValid64}, 64'd0);
    chk("r_ready", 0, {63'd0, oReady64}, 64'd1);
    chk("r_s1",    0, oS1_64,            64'd0);
    chk("r_hit",   0, {63'd0, oHit64},   64'd0);
    @(negedge clk);
    rst = 1'b0;
    iReady = 1'b1;
    rs1_64 = 64'd9; rs2_64 = 64'd4; iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    $display("[TB] post-rst ADD valid=%0d s1=%h s2=%h", oValid64, oS1_64, oS2_64);
    chk("pr_valid", 1, {63'd0, oValid64}, 64'd1);
    chk("pr_s1",    1, oS1_64,            64'd9);
    chk("pr_op",    1, {61'd0, oOp64},    64'd1);
    @(negedge clk);
    chk("pr_nostale", 2, {63'd0, oValid64}, 64'd0);
    @(negedge clk);
    chk("pr_nostale", 3, {63'd0, oValid64}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
